// File: rtl/pifo_dequeue_engine_pkg.sv
// Shared definitions for the PIFO dequeue engine: default widths and the
// congestion FSM state type.
package pifo_dequeue_engine_pkg;

  localparam int DEF_BITPRIO   = 16;
  localparam int DEF_BITDESC   = 32;
  localparam int DEF_CNT_WIDTH = 32;

  typedef enum logic {
    NORMAL,
    CONGESTED
  } cong_state_t;

endpackage

// File: rtl/pifo_dequeue_engine_if.sv
// Valid/ready descriptor stream carrying a rank and a descriptor; master
// drives valid/prio/data, slave drives ready.
interface pifo_dequeue_engine_if
  import pifo_dequeue_engine_pkg::*;
#(
  parameter int BITPRIO = DEF_BITPRIO,
  parameter int BITDESC = DEF_BITDESC
) ();

  logic               valid;
  logic               ready;
  logic [BITPRIO-1:0] prio;
  logic [BITDESC-1:0] data;

  modport master (output valid, output prio, output data, input ready);
  modport slave  (input valid, input prio, input data, output ready);

endinterface

// File: rtl/pifo_dequeue_engine_drop_fifo.sv
// Synchronous drop FIFO with wrap-bit pointers and a first-word-fall-through head.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module pifo_dequeue_engine_drop_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             write;
  logic             read;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign write = push && (!full || pop);
  assign read  = pop && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (read)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pifo_dequeue_engine.sv
// Consumer end of the PIFO wrapper: credit-gated descriptor drain, drop capture
// FIFO, congestion hint back to the wrapper, and dequeue/drop statistics.
module pifo_dequeue_engine
  import pifo_dequeue_engine_pkg::*;
#(
  parameter int BITPRIO         = DEF_BITPRIO,
  parameter int BITDESC         = DEF_BITDESC,
  parameter int MAX_CREDIT      = 16,
  parameter int DROP_FIFO_DEPTH = 8,
  parameter int STARVE_CYCLES   = 64,
  parameter int RESUME_CREDITS  = 4,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  pifo_dequeue_engine_if.slave  pifo_out,
  input  logic                 pifo_out_drop_valid,
  input  logic [BITPRIO-1:0]   pifo_out_drop_prio,
  input  logic [BITDESC-1:0]   pifo_out_drop_data,
  pifo_dequeue_engine_if.master m_desc,
  input  logic                 credit_return,
  pifo_dequeue_engine_if.master m_drop,
  output logic                 cong_hint,
  output logic [CNT_WIDTH-1:0] stat_deq_cnt,
  output logic [CNT_WIDTH-1:0] stat_drop_cnt,
  output logic [CNT_WIDTH-1:0] stat_drop_lost_cnt,
  output logic                 err_credit_ovf
);

  localparam int CRW = $clog2(MAX_CREDIT + 1);
  localparam int STW = $clog2(STARVE_CYCLES + 1);
  localparam logic [CRW-1:0] CREDIT_MAX    = CRW'(MAX_CREDIT);
  localparam logic [CRW-1:0] CREDIT_RESUME = CRW'(RESUME_CREDITS);
  localparam logic [STW-1:0] STARVE_LAST   = STW'(STARVE_CYCLES - 1);

  logic [CRW-1:0]             credit;
  logic [STW-1:0]             starve;
  cong_state_t                state;
  logic                       desc_valid;
  logic [BITPRIO-1:0]         desc_prio;
  logic [BITDESC-1:0]         desc_data;
  logic                       accept;
  logic                       drop_pop;
  logic                       drop_full;
  logic                       drop_empty;
  logic                       drop_lost;
  logic [BITDESC+BITPRIO-1:0] drop_head;

  assign pifo_out.ready = (credit != '0) && (!desc_valid || m_desc.ready);
  assign accept         = pifo_out.valid && pifo_out.ready;

  assign m_desc.valid = desc_valid;
  assign m_desc.prio  = desc_prio;
  assign m_desc.data  = desc_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_valid <= 1'b0;
      desc_prio  <= '0;
      desc_data  <= '0;
    end else if (accept) begin
      desc_valid <= 1'b1;
      desc_prio  <= pifo_out.prio;
      desc_data  <= pifo_out.data;
    end else if (m_desc.ready) begin
      desc_valid <= 1'b0;
    end
  end

  // Credits are consumed at PIFO accept time, so a held output register never
  // lets more descriptors in flight than the downstream can absorb.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit         <= CREDIT_MAX;
      err_credit_ovf <= 1'b0;
    end else begin
      case ({accept, credit_return})
        2'b10: credit <= credit - CRW'(1);
        2'b01: begin
          if (credit == CREDIT_MAX) err_credit_ovf <= 1'b1;
          else                      credit <= credit + CRW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORMAL;
      starve    <= '0;
      cong_hint <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (credit != '0) begin
            starve <= '0;
          end else if (starve == STARVE_LAST) begin
            state     <= CONGESTED;
            cong_hint <= 1'b1;
            starve    <= '0;
          end else begin
            starve <= starve + STW'(1);
          end
        end
        CONGESTED: begin
          if (credit >= CREDIT_RESUME) begin
            state     <= NORMAL;
            cong_hint <= 1'b0;
            starve    <= '0;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  assign drop_pop  = m_drop.valid && m_drop.ready;
  assign drop_lost = pifo_out_drop_valid && drop_full && !drop_pop;

  pifo_dequeue_engine_drop_fifo #(
    .WIDTH (BITDESC + BITPRIO),
    .DEPTH (DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pifo_out_drop_valid),
    .push_data ({pifo_out_drop_data, pifo_out_drop_prio}),
    .pop       (drop_pop),
    .head      (drop_head),
    .full      (drop_full),
    .empty     (drop_empty)
  );

  assign m_drop.valid = !drop_empty;
  assign m_drop.prio  = drop_head[BITPRIO-1:0];
  assign m_drop.data  = drop_head[BITPRIO +: BITDESC];

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_deq_cnt       <= '0;
      stat_drop_cnt      <= '0;
      stat_drop_lost_cnt <= '0;
    end else begin
      if (accept)              stat_deq_cnt       <= stat_deq_cnt + CNT_WIDTH'(1);
      if (pifo_out_drop_valid) stat_drop_cnt      <= stat_drop_cnt + CNT_WIDTH'(1);
      if (drop_lost)           stat_drop_lost_cnt <= stat_drop_lost_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
